period_meter: RTL and testbench

PERIOD_METER -- requirements
Module: period_meter

---
 rtl/period_meter.sv | 141 ++++++++++++++
 tb/tb_period_meter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/period_meter.sv
// period_meter: counts clk cycles between successive sig_in edges, flags stalls and lock.
// Defining PERIOD_METER_MINMAX_EN adds running min_period/max_period outputs.
module period_meter #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 50_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sig_in,
    output logic [WIDTH-1:0] period,
    output logic             valid,
    output logic             locked,
    output logic             timeout
`ifdef PERIOD_METER_MINMAX_EN
    ,
    output logic [WIDTH-1:0] min_period,
    output logic [WIDTH-1:0] max_period
`endif
);

    localparam logic [WIDTH-1:0] TIMEOUT_C = WIDTH'(TIMEOUT);
    localparam logic [WIDTH-1:0] ONE_C     = WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        STALLED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync2_q, dly_q, edge_q;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             locked_q, locked_d;
    logic             timeout_q, timeout_d;
    logic             have_prev_q, have_prev_d;

    // Edge detect is registered so a sampled transition reaches valid three edges later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            dly_q   <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= sig_in;
            sync2_q <= sync1_q;
            dly_q   <= sync2_q;
            edge_q  <= sync2_q ^ dly_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            period_q    <= '0;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
            timeout_q   <= 1'b0;
            have_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            period_q    <= period_d;
            valid_q     <= valid_d;
            locked_q    <= locked_d;
            timeout_q   <= timeout_d;
            have_prev_q <= have_prev_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        period_d    = period_q;
        valid_d     = 1'b0;
        locked_d    = locked_q;
        timeout_d   = timeout_q;
        have_prev_d = have_prev_q;
        case (state_q)
            IDLE: begin
                if (edge_q) begin
                    state_d = MEASURE;
                    count_d = ONE_C;
                end
            end
            MEASURE: begin
                // An edge takes priority over reaching the stall limit in the same cycle.
                if (edge_q) begin
                    period_d    = count_q;
                    valid_d     = 1'b1;
                    count_d     = ONE_C;
                    locked_d    = have_prev_q && (count_q == period_q);
                    have_prev_d = 1'b1;
                end else if (count_q == TIMEOUT_C) begin
                    state_d     = STALLED;
                    timeout_d   = 1'b1;
                    locked_d    = 1'b0;
                    have_prev_d = 1'b0;
                end else begin
                    count_d = count_q + ONE_C;
                end
            end
            STALLED: begin
                if (edge_q) begin
                    state_d   = MEASURE;
                    count_d   = ONE_C;
                    timeout_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign period  = period_q;
    assign valid   = valid_q;
    assign locked  = locked_q;
    assign timeout = timeout_q;

`ifdef PERIOD_METER_MINMAX_EN
    logic [WIDTH-1:0] min_q, max_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            min_q <= '1;
            max_q <= '0;
        end else if (valid_d) begin
            if (period_d < min_q) min_q <= period_d;
            if (period_d > max_q) max_q <= period_d;
        end
    end

    assign min_period = min_q;
    assign max_period = max_q;
`endif

endmodule

// File: tb/tb_period_meter.sv
// Randomized and directed bench for period_meter against a time-stamp based reference model.
module tb_period_meter;
    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 100;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             sig_in = 1'b0;
    logic [WIDTH-1:0] period;
    logic             valid, locked, timeout;
`ifdef PERIOD_METER_MINMAX_EN
    logic [WIDTH-1:0] min_period, max_period;
`endif

    period_meter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk),
        .reset(reset),
        .sig_in(sig_in),
        .period(period),
        .valid(valid),
        .locked(locked),
        .timeout(timeout)
`ifdef PERIOD_METER_MINMAX_EN
        ,
        .min_period(min_period),
        .max_period(max_period)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: edges are time stamps; outputs follow three edges after sampling.
    logic [4:0]       hist;
    int               tcount = 0;
    int               last_t, m_e;
    bit               have_last, stalled, have_prev;
    logic             m_valid, m_locked, m_timeout;
    logic [WIDTH-1:0] m_period;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            hist = '0; have_last = 0; stalled = 0; have_prev = 0;
            m_valid = 0; m_locked = 0; m_timeout = 0; m_period = '0;
        end else begin
            tcount++;
            m_e  = tcount - 3;
            hist = {hist[3:0], sig_in};
            m_valid = 1'b0;
            if (hist[3] != hist[4]) begin
                if (have_last && !stalled) begin
                    m_valid   = 1'b1;
                    m_locked  = have_prev && (WIDTH'(m_e - last_t) == m_period);
                    m_period  = WIDTH'(m_e - last_t);
                    have_prev = 1;
                end
                last_t = m_e; have_last = 1; stalled = 0; m_timeout = 0;
            end else if (have_last && !stalled && (m_e - last_t) >= TIMEOUT) begin
                stalled = 1; m_timeout = 1; m_locked = 0; have_prev = 0;
            end
        end
    end

    // Observations gathered by the stimulus driver.
    int          obs_p[$];
    bit          obs_l[$];
    int          obs_c[$];
    int          mism, to_rise, bad_cyc;
    logic [34:0] bad_dut, bad_mdl;

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; sig_in = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Toggles sig_in at the listed cycles; records strobes and per-cycle model disagreements.
    task automatic drive(input int tt[$], input int total);
        int idx = 0;
        mism = 0; to_rise = -1; bad_cyc = -1;
        obs_p.delete(); obs_l.delete(); obs_c.delete();
        for (int c = 0; c < total; c++) begin
            @(negedge clk);
            if (idx < tt.size() && tt[idx] == c) begin
                sig_in = ~sig_in;
                idx++;
            end
            @(posedge clk);
            #1;
            if ({valid, locked, timeout, period} !== {m_valid, m_locked, m_timeout, m_period}) begin
                if (mism == 0) begin
                    bad_cyc = c;
                    bad_dut = {valid, locked, timeout, period};
                    bad_mdl = {m_valid, m_locked, m_timeout, m_period};
                end
                mism++;
            end
            if (valid === 1'b1) begin
                obs_p.push_back(int'(period));
                obs_l.push_back(locked);
                obs_c.push_back(c);
            end
            if (timeout === 1'b1 && to_rise < 0) to_rise = c;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; sig_in = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({valid, locked, timeout} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: got %b want 000", {valid, locked, timeout});
        end
        n_checks++;
        if (period !== '0) begin
            n_fail++; $display("FAIL reset_period: got %0d want 0", period);
        end
`ifdef PERIOD_METER_MINMAX_EN
        n_checks++;
        if (min_period !== '1 || max_period !== '0) begin
            n_fail++; $display("FAIL reset_minmax: got %h/%h want ffffffff/0", min_period, max_period);
        end
`endif
        reset = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_steady();
        int tt[$];
        do_reset();
        for (int i = 0; i < 8; i++) tt.push_back(i * 10);
        drive(tt, 80);
        n_checks++;
        if (mism != 0) begin
            n_fail++; $display("FAIL steady_model: %0d cycles differ, first c=%0d got %h want %h", mism, bad_cyc, bad_dut, bad_mdl);
        end
        n_checks++;
        if (obs_p.size() != 7) begin
            n_fail++; $display("FAIL steady_count: got %0d strobes want 7", obs_p.size());
        end
        for (int i = 0; i < obs_p.size(); i++) begin
            n_checks++;
            if (obs_p[i] != 10 || obs_l[i] != (i > 0) || (i > 0 && obs_c[i] - obs_c[i-1] != 10)) begin
                n_fail++; $display("FAIL steady_strobe%0d: got p=%0d l=%0b want p=10 l=%0b", i, obs_p[i], obs_l[i], i > 0);
            end
        end
        $display("test_steady done: %0d strobes", obs_p.size());
    endtask

    task automatic test_change();
        do_reset();
        drive('{0, 10, 20, 34}, 45);
        n_checks++;
        if (mism != 0) begin
            n_fail++; $display("FAIL change_model: %0d cycles differ, first c=%0d got %h want %h", mism, bad_cyc, bad_dut, bad_mdl);
        end
        n_checks++;
        if (obs_p.size() != 3 || obs_p[2] != 14 || obs_l[1] != 1'b1 || obs_l[2] != 1'b0) begin
            n_fail++; $display("FAIL change_strobes: got n=%0d last p=%0d want n=3 p=14 locked 1 then 0", obs_p.size(), period);
        end
`ifdef PERIOD_METER_MINMAX_EN
        n_checks++;
        if (min_period !== 32'd10 || max_period !== 32'd14) begin
            n_fail++; $display("FAIL change_minmax: got %0d/%0d want 10/14", min_period, max_period);
        end
`endif
        $display("test_change done");
    endtask

    task automatic test_stall();
        do_reset();
        drive('{0, 10, 20}, 150);
        n_checks++;
        if (mism != 0) begin
            n_fail++; $display("FAIL stall_model: %0d cycles differ, first c=%0d got %h want %h", mism, bad_cyc, bad_dut, bad_mdl);
        end
        n_checks++;
        if (obs_c.size() != 2 || to_rise - obs_c[1] != TIMEOUT) begin
            n_fail++; $display("FAIL stall_timing: timeout at c=%0d, strobes %0d, want %0d cycles after last strobe", to_rise, obs_c.size(), TIMEOUT);
        end
        n_checks++;
        if (period !== 32'd10 || locked !== 1'b0 || timeout !== 1'b1) begin
            n_fail++; $display("FAIL stall_hold: got p=%0d l=%b t=%b want p=10 l=0 t=1", period, locked, timeout);
        end
        drive('{0, 20}, 28);
        n_checks++;
        if (mism != 0 || timeout !== 1'b0) begin
            n_fail++; $display("FAIL stall_exit: %0d model diffs, timeout=%b want 0", mism, timeout);
        end
        n_checks++;
        if (obs_p.size() != 1 || obs_p[0] != 20 || obs_l[0] != 1'b0) begin
            n_fail++; $display("FAIL stall_resume: got n=%0d p=%0d want one strobe p=20 l=0", obs_p.size(), period);
        end
        $display("test_stall done");
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive('{0, 12}, 17);
        n_checks++;
        if (period !== 32'd12 || mism != 0) begin
            n_fail++; $display("FAIL rmid_pre: got p=%0d diffs=%0d want p=12 diffs=0", period, mism);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({valid, locked, timeout} !== 3'b000 || period !== '0) begin
            n_fail++; $display("FAIL rmid_async: got v/l/t=%b p=%0d want 000 p=0", {valid, locked, timeout}, period);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        drive('{2, 12}, 18);
        n_checks++;
        if (mism != 0 || obs_p.size() != 1 || obs_p[0] != 10) begin
            n_fail++; $display("FAIL rmid_after: got n=%0d p=%0d diffs=%0d want one strobe p=10", obs_p.size(), period, mism);
        end
        $display("test_reset_mid done");
    endtask

    task automatic test_release_high();
        @(negedge clk);
        reset = 1'b1; sig_in = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        drive('{14}, 25);
        n_checks++;
        if (mism != 0 || obs_p.size() != 1 || obs_p[0] != 15 || obs_l[0] != 1'b0) begin
            n_fail++; $display("FAIL release_high: got n=%0d p=%0d diffs=%0d want one strobe p=15 l=0", obs_p.size(), period, mism);
        end
        $display("test_release_high done");
    endtask

    task automatic test_latency();
        do_reset();
        drive('{0, 12}, 20);
        n_checks++;
        if (obs_c.size() != 1 || obs_c[0] != 15 || obs_p[0] != 12) begin
            n_fail++; $display("FAIL latency: strobe count %0d at c=%0d want one at c=15 (toggle c=12 + 3)", obs_c.size(), to_rise);
        end
        $display("test_latency done");
    endtask

    task automatic test_boundary();
        do_reset();
        drive('{0, 100, 201, 221}, 230);
        n_checks++;
        if (mism != 0) begin
            n_fail++; $display("FAIL bound_model: %0d cycles differ, first c=%0d got %h want %h", mism, bad_cyc, bad_dut, bad_mdl);
        end
        n_checks++;
        if (obs_p.size() != 2 || obs_p[0] != TIMEOUT || obs_p[1] != 20 || obs_l[1] != 1'b0) begin
            n_fail++; $display("FAIL bound_strobes: got n=%0d p0=%0d want p=100 then p=20", obs_p.size(), obs_p.size() > 0 ? obs_p[0] : -1);
        end
        n_checks++;
        if (to_rise != 100 + TIMEOUT + 3) begin
            n_fail++; $display("FAIL bound_timeout: rose at c=%0d want %0d", to_rise, 100 + TIMEOUT + 3);
        end
        $display("test_boundary done");
    endtask

    task automatic test_random();
        int tt[$];
        int gaps[$];
        int exp_p[$];
        bit exp_l[$];
        int t = 0;
        int emin = 32'h7fffffff;
        int emax = 0;
        do_reset();
        tt.push_back(0);
        for (int i = 0; i < 40; i++) begin
            int g;
            if (i > 0 && $urandom_range(0, 9) < 3) g = gaps[i-1];
            else if ($urandom_range(0, 9) == 0) g = $urandom_range(TIMEOUT - 4, TIMEOUT + 4);
            else g = $urandom_range(1, 30);
            gaps.push_back(g);
            t += g;
            tt.push_back(t);
        end
        for (int j = 0; j < gaps.size(); j++) begin
            if (gaps[j] <= TIMEOUT) begin
                exp_p.push_back(gaps[j]);
                exp_l.push_back(j > 0 && gaps[j-1] <= TIMEOUT && gaps[j] == gaps[j-1]);
                if (gaps[j] < emin) emin = gaps[j];
                if (gaps[j] > emax) emax = gaps[j];
            end
        end
        drive(tt, t + TIMEOUT + 20);
        n_checks++;
        if (mism != 0) begin
            n_fail++; $display("FAIL rand_model: %0d cycles differ, first c=%0d got %h want %h", mism, bad_cyc, bad_dut, bad_mdl);
        end
        n_checks++;
        if (obs_p.size() != exp_p.size()) begin
            n_fail++; $display("FAIL rand_count: got %0d strobes want %0d", obs_p.size(), exp_p.size());
        end
        for (int i = 0; i < obs_p.size() && i < exp_p.size(); i++) begin
            n_checks++;
            if (obs_p[i] != exp_p[i] || obs_l[i] != exp_l[i]) begin
                n_fail++; $display("FAIL rand_strobe%0d: got p=%0d l=%0b want p=%0d l=%0b", i, obs_p[i], obs_l[i], exp_p[i], exp_l[i]);
            end
        end
        n_checks++;
        if (timeout !== 1'b1) begin
            n_fail++; $display("FAIL rand_final_stall: timeout=%b want 1", timeout);
        end
`ifdef PERIOD_METER_MINMAX_EN
        n_checks++;
        if (min_period !== WIDTH'(emin) || max_period !== WIDTH'(emax)) begin
            n_fail++; $display("FAIL rand_minmax: got %0d/%0d want %0d/%0d", min_period, max_period, emin, emax);
        end
`endif
        $display("test_random done: %0d toggles, %0d strobes", tt.size(), obs_p.size());
    endtask

    initial begin
        test_reset();
        test_steady();
        test_change();
        test_stall();
        test_reset_mid();
        test_release_high();
        test_latency();
        test_boundary();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
